// File: rtl/digitube_pkg.sv
// Shared constants, display bundle type and hex-to-segment table
// for the 4-digit seven-segment scanning driver.
package digitube_pkg;

    localparam logic [6:0]  SEG_BLANK = 7'h7F;
    localparam logic [11:0] OUT_RESET = 12'h0FF;

    localparam int AN_MSB  = 11;
    localparam int AN_LSB  = 8;
    localparam int DP_BIT  = 7;
    localparam int SEG_MSB = 6;

    typedef struct packed {
        logic [15:0] val;
        logic [3:0]  dp;
        logic [3:0]  en;
    } disp_t;

    // Segment patterns are CG..CA, active-low.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        s = SEG_BLANK;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/digitube_driver_hex7seg.sv
// hex7seg_decoder: combinational hex nibble to active-low segments.
// Ports: nib_i (4b hex digit), seg_o (7b CG..CA, active-low).
module hex7seg_decoder
    import digitube_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex7(nib_i);

endmodule

// File: rtl/digitube_driver.sv
// digitube_driver: scans a 16-bit hex value, per-digit DP and enable onto
// the 12-bit bus {AN3..AN0, DP, CG..CA}; loads take effect on frame bounds.
// Ports: clk, reset (sync, active-high), value, dp_in, digit_en, load,
//        busy (load pending), digi_out (registered scan bus).
// Build option: DIGITUBE_LZ_BLANK_EN enables leading-zero blanking.
module digitube_driver
    import digitube_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int CNT_W    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    input  logic        load,
    output logic        busy,
    output logic [11:0] digi_out
);

    if (SCAN_DIV < 2) begin : g_bad_div
        $error("digitube_driver: SCAN_DIV must be at least 2");
    end
    if ((64'd1 << CNT_W) < 64'(SCAN_DIV)) begin : g_bad_cnt_w
        $error("digitube_driver: CNT_W too narrow for SCAN_DIV");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    disp_t            pend_q, pend_d;
    logic             pvld_q, pvld_d;
    disp_t            disp_q, disp_d;
    logic [11:0]      out_q, out_d;

    logic       tick;
    logic       wrap;
    logic       lz;
    logic [3:0] nib;
    logic [6:0] seg;
    disp_t      incoming;

    assign incoming = '{val: value, dp: dp_in, en: digit_en};
    assign nib      = disp_q.val[{idx_q, 2'b00} +: 4];

    hex7seg_decoder u_dec (
        .nib_i (nib),
        .seg_o (seg)
    );

    // A digit is a leading zero when it and every higher nibble are 0.
`ifdef DIGITUBE_LZ_BLANK_EN
    always_comb begin
        lz = 1'b0;
        case (idx_q)
            2'd3:    lz = (disp_q.val[15:12] == 4'h0);
            2'd2:    lz = (disp_q.val[15:8]  == 8'h00);
            2'd1:    lz = (disp_q.val[15:4]  == 12'h000);
            default: lz = 1'b0;
        endcase
    end
`else
    assign lz = 1'b0;
`endif

    always_comb begin
        tick   = (cnt_q == CNT_W'(SCAN_DIV - 1));
        wrap   = tick && (idx_q == 2'd3);
        cnt_d  = tick ? '0 : cnt_q + 1'b1;
        idx_d  = tick ? idx_q + 2'd1 : idx_q;
        pend_d = pend_q;
        pvld_d = pvld_q;
        disp_d = disp_q;

        // A load landing on the wrap bypasses the pending slot.
        if (load && wrap) begin
            disp_d = incoming;
            pvld_d = 1'b0;
        end else if (load) begin
            pend_d = incoming;
            pvld_d = 1'b1;
        end else if (wrap && pvld_q) begin
            disp_d = pend_q;
            pvld_d = 1'b0;
        end

        out_d = OUT_RESET;
        if (disp_q.en[idx_q]) begin
            out_d[AN_MSB:AN_LSB] = 4'b0001 << idx_q;
            out_d[DP_BIT]        = ~disp_q.dp[idx_q];
            out_d[SEG_MSB:0]     = lz ? SEG_BLANK : seg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            idx_q  <= 2'd0;
            pend_q <= '0;
            pvld_q <= 1'b0;
            disp_q <= '0;
            out_q  <= OUT_RESET;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            pend_q <= pend_d;
            pvld_q <= pvld_d;
            disp_q <= disp_d;
            out_q  <= out_d;
        end
    end

    assign busy     = pvld_q;
    assign digi_out = out_q;

endmodule

// File: tb/tb_digitube_driver.sv
// Directed bench for digitube_driver with a cycle-count based reference
// model compared every cycle, plus hand-computed literal checks.
module tb_digitube_driver;

    localparam int SD = 4;
    localparam int FR = 4 * SD;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en = '0;
    logic        busy;
    logic [11:0] digi_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    digitube_driver #(.SCAN_DIV(SD), .CNT_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .value    (value),
        .dp_in    (dp_in),
        .digit_en (digit_en),
        .load     (load),
        .busy     (busy),
        .digi_out (digi_out)
    );

    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                             7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                             7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic logic [11:0] enc(int s, logic [15:0] v,
                                        logic [3:0] dp, logic [3:0] en);
        logic [15:0] hi;
        logic        blank;
        logic [6:0]  sg;
        logic [3:0]  an;
        hi = v >> (4 * s);
        blank = 1'b0;
`ifdef DIGITUBE_LZ_BLANK_EN
        blank = (s > 0) && (hi == 16'h0);
`endif
        if (!en[s]) return 12'h0FF;
        sg = blank ? 7'h7F : tbl[hi[3:0]];
        an = 4'b0001 << s;
        return {an, ~dp[s], sg};
    endfunction

    // Model: k counts clock edges since reset release; slot and frame
    // wrap follow directly from k by division.
    int          k = 0;
    logic [15:0] m_val = '0, p_val = '0;
    logic [3:0]  m_dp = '0, m_en = '0, p_dp = '0, p_en = '0;
    logic        pv = 1'b0;
    logic [11:0] exp_digi = 12'h0FF;
    logic        exp_busy = 1'b0;
    logic        chk_on = 1'b0;

    always @(posedge clk) begin : mdl
        logic w;
        if (reset) begin
            k <= 0;
            m_val <= '0; m_dp <= '0; m_en <= '0;
            pv <= 1'b0;
            exp_digi <= 12'h0FF;
            exp_busy <= 1'b0;
        end else begin
            w = (k % FR) == FR - 1;
            exp_digi <= enc((k / SD) % 4, m_val, m_dp, m_en);
            if (load && w) begin
                m_val <= value; m_dp <= dp_in; m_en <= digit_en;
                pv <= 1'b0; exp_busy <= 1'b0;
            end else if (load) begin
                p_val <= value; p_dp <= dp_in; p_en <= digit_en;
                pv <= 1'b1; exp_busy <= 1'b1;
            end else if (w && pv) begin
                m_val <= p_val; m_dp <= p_dp; m_en <= p_en;
                pv <= 1'b0; exp_busy <= 1'b0;
            end else begin
                exp_busy <= pv;
            end
            k <= k + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            checks++;
            if (digi_out !== exp_digi) begin
                errors++;
                $display("FAIL cyc_digi k=%0d got %h want %h",
                         k, digi_out, exp_digi);
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL cyc_busy k=%0d got %b want %b",
                         k, busy, exp_busy);
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic lit(string nm, logic [11:0] act, logic [11:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, want);
        end
    endtask

    task automatic goto(int r);
        int n;
        n = 0;
        while ((k % FR) != r && n < 4 * FR) begin
            step(1);
            n++;
        end
        checks++;
        if ((k % FR) != r) begin
            errors++;
            $display("FAIL goto got %0d want %0d", k % FR, r);
        end
    endtask

    task automatic do_load(logic [15:0] v, logic [3:0] dp, logic [3:0] en);
        value = v; dp_in = dp; digit_en = en;
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    task automatic show(int s, logic [11:0] want, string nm);
        goto(s * SD);
        step(1);
        lit(nm, digi_out, want);
    endtask

    initial begin
        reset = 1'b1;
        step(3);
        chk_on = 1'b1;
        lit("rst_digi", digi_out, 12'h0FF);
        lit("rst_busy", {11'h0, busy}, 12'h000);
        reset = 1'b0;
        step(1);
        lit("idle_dark", digi_out, 12'h0FF);

        goto(5);
        do_load(16'h12AF, 4'b0100, 4'hF);
        lit("busy_set", {11'h0, busy}, 12'h001);
        goto(FR - 1);
        step(1);
        lit("busy_clr", {11'h0, busy}, 12'h000);
        show(0, 12'h18E, "s0_F");
        show(1, 12'h288, "s1_A");
        show(2, 12'h424, "s2_2dp");
        show(3, 12'h8F9, "s3_1");

        goto(3);
        do_load(16'h1111, 4'h0, 4'hF);
        goto(8);
        do_load(16'h2222, 4'h0, 4'hF);
        goto(FR - 1);
        step(1);
        show(0, 12'h1A4, "last_wins");

        goto(FR - 1);
        do_load(16'h3333, 4'h0, 4'hF);
        lit("wrap_busy", {11'h0, busy}, 12'h000);
        show(0, 12'h1B0, "wrap_load");

        goto(FR - 1);
        do_load(16'h8888, 4'h0, 4'b0101);
        show(0, 12'h180, "en_s0");
        show(1, 12'h0FF, "en_s1");
        show(2, 12'h480, "en_s2");
        show(3, 12'h0FF, "en_s3");

        goto(2);
        do_load(16'h4444, 4'h0, 4'hF);
        lit("pre_rst_busy", {11'h0, busy}, 12'h001);
        goto(9);
        reset = 1'b1;
        step(1);
        lit("mid_rst_digi", digi_out, 12'h0FF);
        lit("mid_rst_busy", {11'h0, busy}, 12'h000);
        reset = 1'b0;
        step(FR + 3);
        lit("post_rst_digi", digi_out, 12'h0FF);
        lit("post_rst_busy", {11'h0, busy}, 12'h000);

        goto(FR - 1);
        do_load(16'h0050, 4'h0, 4'hF);
`ifdef DIGITUBE_LZ_BLANK_EN
        show(0, 12'h1C0, "lz_s0");
        show(1, 12'h292, "lz_s1");
        show(2, 12'h4FF, "lz_s2");
        show(3, 12'h8FF, "lz_s3");
`else
        show(0, 12'h1C0, "nz_s0");
        show(1, 12'h292, "nz_s1");
        show(2, 12'h4C0, "nz_s2");
        show(3, 12'h8C0, "nz_s3");
`endif
        goto(FR - 1);
        do_load(16'h0000, 4'h0, 4'hF);
        show(0, 12'h1C0, "zero_s0");
`ifdef DIGITUBE_LZ_BLANK_EN
        show(1, 12'h2FF, "zero_s1");
`else
        show(1, 12'h2C0, "zero_s1");
`endif
        step(4);
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
